// File: rtl/dog_pkg.sv
`default_nettype none
// ============================================================================
// Package : dog_pkg
// Brief   : Shared pixel type, reader state encoding and neighbourhood
//           constants for the DoG extrema reader.
// Rev     : 1.0  initial release
// ============================================================================
package dog_pkg;

    typedef logic signed [8:0] dog_pix_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EVAL  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } rd_state_t;

    localparam int NBR_COUNT  = 9;
    localparam int CENTRE_IDX = 4;

endpackage
`default_nettype wire

// File: rtl/dog_extrema_reader_compare.sv
`default_nettype none
// ============================================================================
// Module  : extrema_compare
// Brief   : Combinational strict local max/min test of a 3x3 neighbourhood
//           held in row-major order, centre at CENTRE_IDX.
// Rev     : 1.0  initial release
// ============================================================================
module extrema_compare
    import dog_pkg::*;
(
    input  dog_pix_t nbr [NBR_COUNT],
    output logic     is_max,
    output logic     is_min
);

    // Any tie with a neighbour clears both flags, so flat regions never fire.
    always_comb begin
        is_max = 1'b1;
        is_min = 1'b1;
        for (int k = 0; k < NBR_COUNT; k++) begin
            if (k != CENTRE_IDX) begin
                if (nbr[CENTRE_IDX] <= nbr[k]) is_max = 1'b0;
                if (nbr[CENTRE_IDX] >= nbr[k]) is_min = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dog_extrema_reader.sv
`default_nettype none
// ============================================================================
// Module  : dog_extrema_reader
// Brief   : Scans interior DoG pixels, fetches each 3x3 neighbourhood and
//           streams strict local extrema as (x, y, polarity).
//           Optional macro EXTREMA_THRESH_EN adds a |centre| >= THRESHOLD gate.
// Rev     : 1.0  initial release
// ============================================================================
module dog_extrema_reader
    import dog_pkg::*;
#(
    parameter  int DIMENSION    = 64,
    parameter  int BRAM_LATENCY = 2,
    parameter  int THRESHOLD    = 4,
    localparam int ADDR_W       = $clog2(DIMENSION*DIMENSION),
    localparam int COORD_W      = $clog2(DIMENSION)
)(
    input  logic               clk,
    input  logic               rst_in,
    input  logic               start,
    output logic               busy,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [8:0]         rd_data,
    output logic               kp_valid,
    input  logic               kp_ready,
    output logic [COORD_W-1:0] kp_x,
    output logic [COORD_W-1:0] kp_y,
    output logic               kp_is_max,
    output logic [ADDR_W-1:0]  kp_count,
    output logic               done
);

    localparam int PH_LAST = NBR_COUNT - 1 + BRAM_LATENCY;
    localparam int PH_W    = $clog2(PH_LAST + 1);
    localparam logic [COORD_W-1:0] C_LAST = COORD_W'(DIMENSION - 2);

    rd_state_t           state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]  nx, ny;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [COORD_W-1:0]  kp_x_q, kp_x_d, kp_y_q, kp_y_d;
    logic                kp_is_max_q, kp_is_max_d;
    logic [ADDR_W-1:0]   kp_count_q, kp_count_d;
    dog_pix_t            samp_q [NBR_COUNT];
    logic                is_max, is_min, thr_ok, hit, last_pix;

    function automatic logic [ADDR_W-1:0] nbr_addr(
        input logic [COORD_W-1:0] cx,
        input logic [COORD_W-1:0] cy,
        input int                 k
    );
        int row;
        int col;
        row = int'(cy) + k / 3 - 1;
        col = int'(cx) + k % 3 - 1;
        return ADDR_W'(row * DIMENSION + col);
    endfunction

    extrema_compare u_cmp (
        .nbr    (samp_q),
        .is_max (is_max),
        .is_min (is_min)
    );

`ifdef EXTREMA_THRESH_EN
    // Widened to 10 bits so that |-256| is representable.
    logic signed [9:0] centre_ext, centre_abs;
    assign centre_ext = 10'(samp_q[CENTRE_IDX]);
    assign centre_abs = (centre_ext < 0) ? -centre_ext : centre_ext;
    assign thr_ok     = (int'(centre_abs) >= THRESHOLD);
`else
    logic [31:0] unused_threshold;
    assign unused_threshold = THRESHOLD;
    assign thr_ok           = 1'b1;
`endif

    assign hit      = (is_max || is_min) && thr_ok;
    assign last_pix = (x_q == C_LAST) && (y_q == C_LAST);
    assign nx       = (x_q == C_LAST) ? COORD_W'(1) : x_q + COORD_W'(1);
    assign ny       = (x_q == C_LAST) ? y_q + COORD_W'(1) : y_q;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        ph_d        = ph_q;
        rd_addr_d   = rd_addr_q;
        kp_x_d      = kp_x_q;
        kp_y_d      = kp_y_q;
        kp_is_max_d = kp_is_max_q;
        kp_count_d  = kp_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    x_d        = COORD_W'(1);
                    y_d        = COORD_W'(1);
                    ph_d       = '0;
                    rd_addr_d  = nbr_addr(COORD_W'(1), COORD_W'(1), 0);
                    kp_count_d = '0;
                end
            end
            ST_FETCH: begin
                ph_d = ph_q + PH_W'(1);
                if (int'(ph_q) < NBR_COUNT - 1) begin
                    rd_addr_d = nbr_addr(x_q, y_q, int'(ph_q) + 1);
                end
                if (int'(ph_q) == PH_LAST) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (hit) begin
                    state_d     = ST_EMIT;
                    kp_x_d      = x_q;
                    kp_y_d      = y_q;
                    kp_is_max_d = is_max;
                end else if (last_pix) begin
                    state_d = ST_DONE;
                end else begin
                    state_d   = ST_FETCH;
                    x_d       = nx;
                    y_d       = ny;
                    ph_d      = '0;
                    rd_addr_d = nbr_addr(nx, ny, 0);
                end
            end
            ST_EMIT: begin
                if (kp_ready) begin
                    if (kp_count_q != '1) begin
                        kp_count_d = kp_count_q + ADDR_W'(1);
                    end
                    if (last_pix) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_FETCH;
                        x_d       = nx;
                        y_d       = ny;
                        ph_d      = '0;
                        rd_addr_d = nbr_addr(nx, ny, 0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            x_q         <= '0;
            y_q         <= '0;
            ph_q        <= '0;
            rd_addr_q   <= '0;
            kp_x_q      <= '0;
            kp_y_q      <= '0;
            kp_is_max_q <= 1'b0;
            kp_count_q  <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            ph_q        <= ph_d;
            rd_addr_q   <= rd_addr_d;
            kp_x_q      <= kp_x_d;
            kp_y_q      <= kp_y_d;
            kp_is_max_q <= kp_is_max_d;
            kp_count_q  <= kp_count_d;
        end
    end

    // Sample k arrives BRAM_LATENCY cycles after its address was driven.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NBR_COUNT; i++) begin
                samp_q[i] <= '0;
            end
        end else if (state_q == ST_FETCH) begin
            for (int i = 0; i < NBR_COUNT; i++) begin
                if (int'(ph_q) == i + BRAM_LATENCY) begin
                    samp_q[i] <= rd_data;
                end
            end
        end
    end

    assign busy      = (state_q == ST_FETCH) || (state_q == ST_EVAL) || (state_q == ST_EMIT);
    assign done      = (state_q == ST_DONE);
    assign kp_valid  = (state_q == ST_EMIT);
    assign rd_addr   = rd_addr_q;
    assign kp_x      = kp_x_q;
    assign kp_y      = kp_y_q;
    assign kp_is_max = kp_is_max_q;
    assign kp_count  = kp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dog_extrema_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_dog_extrema_reader
// Brief   : Self-checking bench: BRAM model, raster-scan extrema reference
//           model and keypoint scoreboard on a reduced 16x16 image.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dog_extrema_reader;

    localparam int DIM    = 16;
    localparam int LAT    = 2;
    localparam int THR    = 4;
    localparam int AW     = 8;
    localparam int CW     = 4;
    localparam int BUDGET = 20000;

    typedef struct { int x; int y; bit is_max; } kp_t;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [8:0]    rd_data;
    logic          kp_valid;
    logic          kp_ready;
    logic [CW-1:0] kp_x, kp_y;
    logic          kp_is_max;
    logic [AW-1:0] kp_count;
    logic          done;

    logic signed [8:0] mem [DIM*DIM];
    logic [8:0]        pipe [LAT];
    kp_t               exp_q [$];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe[0] <= mem[rd_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[LAT-1];

    dog_extrema_reader #(
        .DIMENSION    (DIM),
        .BRAM_LATENCY (LAT),
        .THRESHOLD    (THR)
    ) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .start     (start),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .kp_valid  (kp_valid),
        .kp_ready  (kp_ready),
        .kp_x      (kp_x),
        .kp_y      (kp_y),
        .kp_is_max (kp_is_max),
        .kp_count  (kp_count),
        .done      (done)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < DIM*DIM; i++) mem[i] = '0;
    endtask

    function automatic int px(input int x, input int y);
        return int'(mem[y*DIM + x]);
    endfunction

    // Reference: raster scan of interior pixels, strict compare against all 8 neighbours.
    task automatic build_expected();
        exp_q.delete();
        for (int y = 1; y <= DIM-2; y++) begin
            for (int x = 1; x <= DIM-2; x++) begin
                int  c;
                bit  gt, lt, ok;
                c  = px(x, y);
                gt = 1'b1;
                lt = 1'b1;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0) begin
                            if (!(c > px(x+dx, y+dy))) gt = 1'b0;
                            if (!(c < px(x+dx, y+dy))) lt = 1'b0;
                        end
                ok = 1'b1;
`ifdef EXTREMA_THRESH_EN
                ok = ((c < 0) ? -c : c) >= THR;
`endif
                if ((gt || lt) && ok) exp_q.push_back('{x: x, y: y, is_max: gt});
            end
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: hold ready low 5 cycles on first keypoint
    task automatic run_scan(input int mode, input bit check_timing);
        int            cyc, busy_cyc, stall_cnt, exp_n;
        bit            seen_done, pv, pr, pm;
        logic [CW-1:0] pxx, pyy;
        logic [AW-1:0] pa;
        kp_t           e;
        build_expected();
        exp_n     = exp_q.size();
        cyc       = 0;
        busy_cyc  = 0;
        stall_cnt = 0;
        seen_done = 1'b0;
        pv        = 1'b0;
        pr        = 1'b1;
        @(negedge clk);
        start    = 1'b1;
        kp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!seen_done && cyc < BUDGET) begin
            if (cyc < 9) check_eq("issue_addr", int'(rd_addr), (cyc/3)*DIM + cyc%3);
            if (pv && !pr) begin
                check_eq("stall_valid", int'(kp_valid), 1);
                check_eq("stall_x", int'(kp_x), int'(pxx));
                check_eq("stall_y", int'(kp_y), int'(pyy));
                check_eq("stall_pol", int'(kp_is_max), int'(pm));
                check_eq("stall_addr", int'(rd_addr), int'(pa));
            end
            if (busy) busy_cyc++;
            if (done) begin
                seen_done = 1'b1;
                check_eq("done_busy", int'(busy), 0);
                check_eq("kp_count", int'(kp_count), exp_n);
                check_eq("done_valid", int'(kp_valid), 0);
            end else begin
                case (mode)
                    1:       kp_ready = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (kp_valid && stall_cnt < 5) begin
                            kp_ready = 1'b0;
                            stall_cnt++;
                        end else begin
                            kp_ready = 1'b1;
                        end
                    end
                    default: kp_ready = 1'b1;
                endcase
                start = (cyc == 30);
                if (kp_valid && kp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("kp_extra", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("kp_x", int'(kp_x), e.x);
                        check_eq("kp_y", int'(kp_y), e.y);
                        check_eq("kp_is_max", int'(kp_is_max), int'(e.is_max));
                    end
                end
                pv  = kp_valid;
                pr  = kp_ready;
                pxx = kp_x;
                pyy = kp_y;
                pm  = kp_is_max;
                pa  = rd_addr;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen_done) check_eq("done_timeout", 0, 1);
        check_eq("kp_missing", exp_q.size(), 0);
        if (check_timing)
            check_eq("scan_cycles", busy_cyc, (DIM-2)*(DIM-2)*(9+LAT+1) + exp_n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_width", int'(done), 0);
        check_eq("start_in_done", int'(busy), 0);
    endtask

    task automatic reset_mid_fetch();
        clear_img();
        mem[1*DIM + 2] = 9'sd100;
        @(negedge clk);
        start    = 1'b1;
        kp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("pre_rst_count", int'(kp_count), 1);
        check_eq("pre_rst_busy", int'(busy), 1);
        #2 rst_in = 1'b0;
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_valid", int'(kp_valid), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_addr", int'(rd_addr), 0);
        check_eq("rst_count", int'(kp_count), 0);
        check_eq("rst_kp_x", int'(kp_x), 0);
        check_eq("rst_kp_y", int'(kp_y), 0);
        check_eq("rst_pol", int'(kp_is_max), 0);
        @(negedge clk);
        rst_in = 1'b1;
        run_scan(0, 1'b1);
    endtask

    initial begin
        rst_in   = 1'b0;
        start    = 1'b0;
        kp_ready = 1'b1;
        clear_img();
        repeat (3) @(negedge clk);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_valid", int'(kp_valid), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_addr", int'(rd_addr), 0);
        check_eq("reset_count", int'(kp_count), 0);
        rst_in = 1'b1;

        clear_img();
        run_scan(0, 1'b1);

        clear_img();
        mem[12*DIM + 10] = 9'sd100;
        run_scan(0, 1'b1);

        clear_img();
        mem[5*DIM + 5] = -9'sd50;
        mem[0]         = 9'sd7;
        run_scan(0, 1'b1);

        clear_img();
        mem[7*DIM + 7] = 9'sd100;
        mem[7*DIM + 8] = 9'sd100;
        run_scan(0, 1'b1);

        clear_img();
        mem[12*DIM + 10] = 9'sd100;
        run_scan(2, 1'b0);

        clear_img();
        mem[4*DIM + 4] = 9'sd3;
        mem[9*DIM + 9] = -9'sd256;
        run_scan(0, 1'b1);

        reset_mid_fetch();

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DIM*DIM; i++) mem[i] = 9'(int'($urandom_range(0, 16)) - 8);
            run_scan(1, 1'b0);
        end

        clear_img();
        for (int i = 0; i < 20; i++)
            mem[$urandom_range(0, DIM*DIM-1)] = 9'(int'($urandom_range(0, 511)) - 256);
        run_scan(0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
